// File: rtl/intc_pkg.sv
// intc_pkg -- shared definitions for the interrupt controller front end.
//
// Contents:
//   state_t   : controller state (IDLE, REQ, SERVICE)
//   NIRQ_DEF  : default number of interrupt lines
//   TMO_DEF   : default acknowledge timeout in clk cycles
//   VEC_W     : width of the vector index for the default line count
//   CNT_W     : width of the timeout counter (covers TMO up to 255)

package intc_pkg;

    localparam int NIRQ_DEF = 4;
    localparam int TMO_DEF  = 16;
    localparam int VEC_W    = $clog2(NIRQ_DEF);
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intc_edge_sync.sv
// intc_edge_sync -- per-line input conditioning for the interrupt front end.
//
// Turns one raw, asynchronous event line into a one-cycle rise strobe that
// is aligned to clk.
//
// Build option:
//   INTC_SYNC_EN defined   : a two-flop synchronizer sits in front of the
//                            edge detector (rise strobe 3 cycles after the
//                            first sampling edge).
//   INTC_SYNC_EN undefined : irq goes straight into the edge detector
//                            (rise strobe 1 cycle after the first sampling edge).
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, clears every flop
//   irq   : raw event line, rising edge significant
//   rise  : high for one cycle per detected rising edge

module intc_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic rise
);

    logic src;
    logic cur;
    logic prev;

`ifdef INTC_SYNC_EN
    logic meta;
    logic sync;

    // Two-flop synchronizer: the first flop may go metastable, the second
    // gives it a full cycle to settle before the edge detector looks at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= irq;
            sync <= meta;
        end
    end

    assign src = sync;
`else
    assign src = irq;
`endif

    // Edge detector history.  Both flops clear on reset, so a line that is
    // already high when reset releases is seen as exactly one fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= src;
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;

endmodule

// File: rtl/intc_front.sv
// intc_front -- interrupt controller front end.
//
// Latches rising edges of the external lines into a pending register,
// picks the lowest-index unmasked pending line, presents it to the CPU as a
// one-hot request and tracks the acknowledge / end-of-interrupt handshake.
// A request left unacknowledged for TMO cycles is withdrawn (pending kept)
// and a sticky timeout flag is raised.
//
// Build option: INTC_SYNC_EN adds a two-flop synchronizer per line inside
// intc_edge_sync (see that file).
//
// Parameters:
//   NIRQ : number of interrupt lines
//   TMO  : acknowledge timeout in clk cycles (2..255)
//
// Ports:
//   clk        : clock
//   reset      : synchronous active-high reset
//   irq_in     : raw event lines, rising edge significant
//   mask_we    : write strobe for the mask register
//   mask_d     : new mask value (1 = line masked)
//   ack        : CPU acknowledge of the presented request
//   eoi        : CPU end-of-interrupt
//   ie         : one-hot request to the CPU (bit 0 -> ie1 ... bit 3 -> ie4)
//   vec        : index of the presented / in-service line
//   pending    : latched edges not yet acknowledged
//   in_service : high while a handler is running
//   tmo_flag   : sticky acknowledge-timeout indication

module intc_front
    import intc_pkg::*;
#(
    parameter int NIRQ = NIRQ_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NIRQ-1:0]         irq_in,
    input  logic                    mask_we,
    input  logic [NIRQ-1:0]         mask_d,
    input  logic                    ack,
    input  logic                    eoi,
    output logic [NIRQ-1:0]         ie,
    output logic [$clog2(NIRQ)-1:0] vec,
    output logic [NIRQ-1:0]         pending,
    output logic                    in_service,
    output logic                    tmo_flag
);

    localparam int VW = $clog2(NIRQ);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

    logic [NIRQ-1:0]  rise;
    logic [NIRQ-1:0]  mask;
    logic [NIRQ-1:0]  cand;
    logic [NIRQ-1:0]  ack_clr;
    logic [NIRQ-1:0]  ie_nxt;
    logic [VW-1:0]    vec_nxt;
    logic [VW-1:0]    win;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tmo_set;
    state_t           state;
    state_t           state_nxt;

    for (genvar g = 0; g < NIRQ; g++) begin : g_line
        intc_edge_sync u_edge (
            .clk   (clk),
            .reset (reset),
            .irq   (irq_in[g]),
            .rise  (rise[g])
        );
    end

    // Priority pick over the registered candidate set.  Scanning from the
    // top down lets the lowest index overwrite everything above it, so
    // line 0 always wins.
    always_comb begin
        win = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win = VW'(i);
            end
        end
    end

    // Next-state and registered-output logic.  ie/vec are loaded together
    // with the move into REQ so they are valid on the very first REQ cycle,
    // and they are never recomputed while in REQ, which is what freezes the
    // winner against later edges or mask writes.  ack takes priority over
    // the timeout on the last REQ cycle.
    always_comb begin
        state_nxt = state;
        ie_nxt    = ie;
        vec_nxt   = vec;
        cnt_nxt   = cnt;
        ack_clr   = '0;
        tmo_set   = 1'b0;
        case (state)
            IDLE: begin
                if (|cand) begin
                    state_nxt = REQ;
                    ie_nxt    = NIRQ'(1) << win;
                    vec_nxt   = win;
                    cnt_nxt   = '0;
                end
            end
            REQ: begin
                if (ack) begin
                    state_nxt = SERVICE;
                    ie_nxt    = '0;
                    ack_clr   = ie;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = IDLE;
                    ie_nxt    = '0;
                    tmo_set   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ie_nxt    = '0;
            end
        endcase
    end

    // FSM state register together with the registered CPU-facing request
    // outputs and the REQ dwell counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ie    <= '0;
            vec   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ie    <= ie_nxt;
            vec   <= vec_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Pending, mask, candidate and timeout-flag bookkeeping.  A fresh edge
    // is OR-ed in after the acknowledge clear so a same-cycle edge survives.
    // The candidate set is a registered snapshot of unmasked pending lines;
    // it gives the extra cycle between pending becoming visible and ie
    // rising, and it means a mask write only takes effect a cycle later.
    // The timeout set beats a simultaneous mask-write clear so a timeout is
    // never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            mask     <= '0;
            cand     <= '0;
            tmo_flag <= 1'b0;
        end else begin
            pending <= (pending & ~ack_clr) | rise;
            cand    <= pending & ~mask;
            if (mask_we) begin
                mask <= mask_d;
            end
            if (tmo_set) begin
                tmo_flag <= 1'b1;
            end else if (mask_we) begin
                tmo_flag <= 1'b0;
            end
        end
    end

    assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_intc_front.sv
// tb_intc_front -- self-checking bench for intc_front (NIRQ=4, TMO=16).
//
// A behavioural model tracks what the controller must do from its rules
// (edge arrival delay, lowest-index priority, dwell age, handshake) and a
// compare process checks every DUT output against it on each falling edge.
// Directed scenarios add literal expectations at key points.
// Works with or without INTC_SYNC_EN; the input delay K follows the macro.

module tb_intc_front;

    import intc_pkg::*;

    localparam int NIRQ = 4;
    localparam int TMO  = 16;
`ifdef INTC_SYNC_EN
    localparam int K = 3;
`else
    localparam int K = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [NIRQ-1:0]  irq_in;
    logic             mask_we;
    logic [NIRQ-1:0]  mask_d;
    logic             ack;
    logic             eoi;
    logic [NIRQ-1:0]  ie;
    logic [VEC_W-1:0] vec;
    logic [NIRQ-1:0]  pending;
    logic             in_service;
    logic             tmo_flag;

    int checks = 0;
    int errors = 0;

    intc_front #(.NIRQ(NIRQ), .TMO(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_d     (mask_d),
        .ack        (ack),
        .eoi        (eoi),
        .ie         (ie),
        .vec        (vec),
        .pending    (pending),
        .in_service (in_service),
        .tmo_flag   (tmo_flag)
    );

    always #5 clk = ~clk;

    // Model state: sampled input history (index 0 = newest), pending set,
    // mask, lines that were eligible one cycle ago, mode (0 idle,
    // 1 presenting, 2 serving), presented line and how long it has been shown.
    logic [NIRQ-1:0] hist [0:K];
    logic [NIRQ-1:0] m_pend;
    logic [NIRQ-1:0] m_mask;
    logic [NIRQ-1:0] m_ready;
    logic [NIRQ-1:0] m_rise;
    logic [NIRQ-1:0] m_newpend;
    int              m_mode;
    int              m_line;
    int              m_age;
    logic            m_tmo;
    logic            m_to;
    logic            model_live = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NIRQ-1:0] irq, input logic mwe,
                                 input logic [NIRQ-1:0] md, input logic a,
                                 input logic e);
        irq_in  = irq;
        mask_we = mwe;
        mask_d  = md;
        ack     = a;
        eoi     = e;
        @(negedge clk);
    endtask

    // Behavioural model, advanced once per rising edge from the inputs that
    // were stable across that edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j <= K; j++) hist[j] = '0;
            m_pend  = '0;
            m_mask  = '0;
            m_ready = '0;
            m_mode  = 0;
            m_line  = 0;
            m_age   = 0;
            m_tmo   = 1'b0;
            model_live = 1'b1;
        end else begin
            m_to      = 1'b0;
            m_rise    = hist[K-1] & ~hist[K];
            for (int j = K; j > 0; j--) hist[j] = hist[j-1];
            hist[0]   = irq_in;
            m_newpend = m_pend | m_rise;
            if (m_mode == 0) begin
                if (m_ready != 0) begin
                    for (int i = NIRQ - 1; i >= 0; i--)
                        if (m_ready[i]) m_line = i;
                    m_mode = 1;
                    m_age  = 1;
                end
            end else if (m_mode == 1) begin
                if (ack) begin
                    m_mode = 2;
                    if (!m_rise[m_line]) m_newpend[m_line] = 1'b0;
                end else if (m_age == TMO) begin
                    m_mode = 0;
                    m_to   = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (eoi) begin
                m_mode = 0;
            end
            if (m_to) m_tmo = 1'b1;
            else if (mask_we) m_tmo = 1'b0;
            m_ready = m_pend & ~m_mask;
            if (mask_we) m_mask = mask_d;
            m_pend = m_newpend;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("mdl_ie", ie, (m_mode == 1) ? (4'b0001 << m_line) : 4'b0000);
            if (m_mode != 0) checkOutput("mdl_vec", vec, m_line);
            checkOutput("mdl_pending", pending, m_pend);
            checkOutput("mdl_in_service", in_service, m_mode == 2);
            checkOutput("mdl_tmo_flag", tmo_flag, m_tmo);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("rst_ie", ie, 4'b0000);
        checkOutput("rst_vec", vec, 0);
        checkOutput("rst_pending", pending, 4'b0000);
        checkOutput("rst_in_service", in_service, 1'b0);
        checkOutput("rst_tmo_flag", tmo_flag, 1'b0);
        reset = 1'b0;
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] single line 2 request, handshake, mask during REQ");
        for (int n = 1; n <= K + 3; n++) begin
            applyStimulus((n <= 3) ? 4'b0100 : 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
            if (n == K)     checkOutput("s1_pending_early", pending, 4'b0000);
            if (n == K + 1) checkOutput("s1_pending", pending, 4'b0100);
            if (n == K + 2) checkOutput("s1_ie_early", ie, 4'b0000);
        end
        checkOutput("s1_ie", ie, 4'b0100);
        checkOutput("s1_vec", vec, 2);
        applyStimulus(4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0);
        checkOutput("s1_mask_hold_ie", ie, 4'b0100);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("s1_ack_ie", ie, 4'b0000);
        checkOutput("s1_ack_insvc", in_service, 1'b1);
        checkOutput("s1_ack_pending", pending, 4'b0000);
        checkOutput("s1_svc_vec", vec, 2);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("s1_stray_ack", in_service, 1'b1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        checkOutput("s1_eoi_insvc", in_service, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
        repeat (3) applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] lines 1 and 3 together, priority order");
        for (int n = 1; n <= K + 3; n++)
            applyStimulus((n <= 2) ? 4'b1010 : 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s2_ie_first", ie, 4'b0010);
        checkOutput("s2_vec_first", vec, 1);
        checkOutput("s2_pending", pending, 4'b1010);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("s2_ack_pending", pending, 4'b1000);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        checkOutput("s2_eoi_ie", ie, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s2_ie_second", ie, 4'b1000);
        checkOutput("s2_vec_second", vec, 3);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        repeat (3) applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] masked line 0, then unmask");
        applyStimulus(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
        for (int n = 1; n <= K + 4; n++)
            applyStimulus((n <= 2) ? 4'b0001 : 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s3_masked_pending", pending, 4'b0001);
        checkOutput("s3_masked_ie", ie, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("s3_unmask_ie0", ie, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s3_unmask_ie1", ie, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s3_unmask_ie2", ie, 4'b0001);

        $display("[TB] ack colliding with a new line 0 edge");
        for (int n = 1; n <= K; n++)
            applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("s5_pending_kept", pending, 4'b0001);
        checkOutput("s5_insvc", in_service, 1'b1);
        checkOutput("s5_ie", ie, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1);
        checkOutput("s5_eoi_ie", ie, 4'b0000);

        $display("[TB] acknowledge timeout");
        for (int j = 1; j <= 18; j++) begin
            applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
            if (j == 16) checkOutput("s4_ie_last", ie, 4'b0001);
            if (j == 17) begin
                checkOutput("s4_tmo_ie", ie, 4'b0000);
                checkOutput("s4_tmo_flag", tmo_flag, 1'b1);
                checkOutput("s4_tmo_pending", pending, 4'b0001);
            end
        end
        checkOutput("s4_represent_ie", ie, 4'b0001);
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("s4_flag_sticky", tmo_flag, 1'b1);
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("s4_flag_cleared", tmo_flag, 1'b0);
        repeat (3) applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] reset during service with line 2 held high");
        for (int n = 1; n <= K + 3; n++)
            applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s6_ie", ie, 4'b0100);
        applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("s6_insvc", in_service, 1'b1);
        reset = 1'b1;
        applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s6_rst_ie", ie, 4'b0000);
        checkOutput("s6_rst_insvc", in_service, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s6_rst_vec", vec, 0);
        checkOutput("s6_rst_pending", pending, 4'b0000);
        checkOutput("s6_rst_tmo", tmo_flag, 1'b0);
        reset = 1'b0;
        for (int n = 1; n <= K + 1; n++) begin
            applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
            if (n == K) checkOutput("s6_pending_early", pending, 4'b0000);
        end
        checkOutput("s6_pending_once", pending, 4'b0100);
        repeat (2) applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s6_ie_after", ie, 4'b0100);
        applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1);
        repeat (8) applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("s6_no_second_pending", pending, 4'b0000);
        checkOutput("s6_no_second_ie", ie, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
